// File: rtl/cipher_pkg.sv
// Shared definitions for the XOR stream cipher: FSM states, LFSR taps per width
// and the Galois LFSR step.
package cipher_pkg;

    typedef enum logic {
        NOKEY = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    function automatic logic [31:0] taps_for(input int unsigned w);
        case (w)
            8:       return TAPS_8;
            16:      return TAPS_16;
            default: return TAPS_32;
        endcase
    endfunction

    // Galois right-shift step; callers zero-extend narrower keystreams.
    function automatic logic [31:0] lfsr_next(input logic [31:0] ks, input logic [31:0] taps);
        return (ks >> 1) ^ (ks[0] ? taps : 32'h0);
    endfunction

endpackage

// File: rtl/keystream_gen.sv
// Keystream register: loads on key_load (with LFSR lock-up guard) and, in
// rolling mode, steps the LFSR once per accepted beat.
module keystream_gen
    import cipher_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] key,
    input  logic              mode,
    input  logic              advance,
    output logic [DATA_W-1:0] ks
);

    localparam logic [DATA_W-1:0] TAPS = DATA_W'(taps_for(DATA_W));

    logic rolling;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks      <= '0;
            rolling <= 1'b0;
        end else if (load) begin
            rolling <= mode;
            // An all-zero seed would freeze the LFSR, so substitute 1.
            ks      <= (mode && (key == '0)) ? DATA_W'(1) : key;
        end else if (advance && rolling) begin
            ks <= DATA_W'(lfsr_next(32'(ks), 32'(TAPS)));
        end
    end

endmodule

// File: rtl/xor_stream_cipher.sv
// XOR stream cipher with a valid/ready stream, single output register,
// static or rolling-LFSR keystream and a per-key beat counter.
module xor_stream_cipher
    import cipher_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [DATA_W-1:0] key,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       beat_cnt,
    output logic              keyed
);

    state_t            state;
    logic              accept;
    logic [DATA_W-1:0] ks;

    // Key loads take priority; a held output only blocks intake until it drains.
    assign in_ready = (state == RUN) && !key_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    keystream_gen #(
        .DATA_W (DATA_W)
    ) u_keystream_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (key_load),
        .key     (key),
        .mode    (mode),
        .advance (accept),
        .ks      (ks)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= NOKEY;
            keyed     <= 1'b0;
            beat_cnt  <= 16'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (key_load) begin
                state    <= RUN;
                keyed    <= 1'b1;
                beat_cnt <= 16'd0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 16'd1;
            end

            // A pending beat survives key_load and drains with its old-key value.
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data ^ ks;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Self-checking bench for xor_stream_cipher (DATA_W=8): directed vectors plus
// randomized traffic against a behavioural model.
module tb_xor_stream_cipher;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_load = 1'b0;
    logic [7:0] key = 8'h00;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [15:0] beat_cnt;
    logic       keyed;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit         m_keyed;
    bit         m_roll;
    bit [7:0]   m_ks;
    bit         m_ov;
    bit [7:0]   m_od;
    int         m_cnt;

    always #5 clk = ~clk;

    xor_stream_cipher #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key       (key),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .beat_cnt  (beat_cnt),
        .keyed     (keyed)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit [7:0] ks_step(input bit [7:0] x);
        // Galois right-shift with taps 0xB8
        return x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
    endfunction

    task automatic model_reset();
        m_keyed = 0; m_roll = 0; m_ks = 0; m_ov = 0; m_od = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        if (m_ov) check_eq({tag, ".out_data"}, 32'(out_data), 32'(m_od));
        check_eq({tag, ".beat_cnt"}, 32'(beat_cnt), 32'(m_cnt[15:0]));
        check_eq({tag, ".keyed"}, 32'(keyed), 32'(m_keyed));
    endtask

    // One clock cycle: drive at negedge, check ready, update model at posedge, check outputs.
    task automatic step(input string tag, input bit kl, input bit [7:0] k, input bit md,
                        input bit iv, input bit [7:0] d, input bit ordy);
        bit exp_ready;
        @(negedge clk);
        key_load = kl; key = k; mode = md; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        exp_ready = m_keyed && !kl && (!m_ov || ordy);
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (m_ov && ordy) m_ov = 0;
        if (kl) begin
            m_keyed = 1;
            m_roll  = md;
            m_ks    = (md && k == 0) ? 8'h01 : k;
            m_cnt   = 0;
        end else if (iv && exp_ready) begin
            m_ov  = 1;
            m_od  = d ^ m_ks;
            m_cnt = (m_cnt + 1) % 65536;
            if (m_roll) m_ks = ks_step(m_ks);
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset.out_valid", 32'(out_valid), 32'd0);
        check_eq("reset.out_data", 32'(out_data), 32'd0);
        check_eq("reset.beat_cnt", 32'(beat_cnt), 32'd0);
        check_eq("reset.keyed", 32'(keyed), 32'd0);
        check_eq("reset.in_ready", 32'(in_ready), 32'd0);

        // No key yet: input must be refused
        step("nokey", 0, 8'h00, 0, 1, 8'h55, 1);
        step("nokey2", 0, 8'h00, 0, 1, 8'h66, 1);
        // key_load alongside in_valid: key wins, no beat
        step("kl_prio", 1, 8'hA5, 0, 1, 8'h3C, 1);
        check_eq("kl_prio.cnt0", 32'(beat_cnt), 32'd0);

        // Static key vector
        step("static1", 0, 8'h00, 0, 1, 8'h3C, 1);
        check_eq("static1.const", 32'(out_data), 32'h99);
        step("static2", 0, 8'h00, 0, 1, 8'h3C, 1);
        check_eq("static2.const", 32'(out_data), 32'h99);
        check_eq("static2.cnt", 32'(beat_cnt), 32'd2);
        step("drain", 0, 8'h00, 0, 0, 8'h00, 1);

        // Rolling LFSR vector
        step("roll_kl", 1, 8'h01, 1, 0, 8'h00, 1);
        step("roll1", 0, 8'h00, 0, 1, 8'h00, 1);
        check_eq("roll1.const", 32'(out_data), 32'h01);
        step("roll2", 0, 8'h00, 0, 1, 8'h00, 1);
        check_eq("roll2.const", 32'(out_data), 32'hB8);
        step("roll3", 0, 8'h00, 0, 1, 8'h00, 1);
        check_eq("roll3.const", 32'(out_data), 32'h5C);

        // Pending beat crosses a key_load, then zero-seed guard
        step("guard_kl", 1, 8'h00, 1, 1, 8'h00, 0);
        check_eq("guard_kl.held", 32'(out_data), 32'h5C);
        step("guard1", 0, 8'h00, 0, 1, 8'h00, 1);
        check_eq("guard1.const", 32'(out_data), 32'h01);

        // Backpressure: output held, no intake, keystream frozen
        for (int i = 0; i < 3; i++) step("stall", 0, 8'h00, 0, 1, 8'h00, 0);
        check_eq("stall.held", 32'(out_data), 32'h01);
        for (int i = 0; i < 4; i++) step("stream", 0, 8'h00, 0, 1, 8'($urandom), 1);
        check_eq("stream.cnt", 32'(beat_cnt), 32'd5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit kl = ($urandom_range(0, 31) == 0);
            bit [7:0] k = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step("rand", kl, k, 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 8'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between edges, mid-stream
        step("pre_rst", 1, 8'h37, 1, 1, 8'h00, 1);
        step("pre_rst2", 0, 8'h00, 0, 1, 8'h12, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst.out_valid", 32'(out_valid), 32'd0);
        check_eq("arst.keyed", 32'(keyed), 32'd0);
        check_eq("arst.beat_cnt", 32'(beat_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 0, 8'h00, 0, 1, 8'h44, 1);
        step("post_rst2", 0, 8'h00, 0, 1, 8'h45, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xor_stream_cipher.md
XOR_STREAM_CIPHER -- requirements
Module: xor_stream_cipher

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data/key width in bits; legal values are 8, 16 and 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port key_load, input, 1 bit: load key into the keystream register this cycle.
REQ-005 SHALL have port key, input, DATA_W bits: key/seed value sampled when key_load=1.
REQ-006 SHALL have port mode, input, 1 bit: 0 = static key; 1 = rolling LFSR keystream. Sampled only on key_load.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-009 SHALL have port in_data, input, DATA_W bits: plaintext/ciphertext beat.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-012 SHALL have port out_data, output, DATA_W bits: in_data XOR keystream.
REQ-013 SHALL have port beat_cnt, output, 16 bits: number of beats accepted since the last key_load.
REQ-014 SHALL have port keyed, output, 1 bit: a key has been loaded since reset.

Function
REQ-015 SHALL implement an FSM with states NOKEY and RUN; reset enters NOKEY; key_load=1 in either state moves to RUN; there is no other transition.
REQ-016 SHALL hold in_ready=0 in NOKEY and in any cycle with key_load=1.
REQ-017 SHALL drive in_ready = (state==RUN) && !key_load && (!out_valid || out_ready), so that one output register provides full throughput.
REQ-018 SHALL accept a beat when in_valid && in_ready; on the next edge it registers out_data = in_data XOR ks, sets out_valid=1 and increments beat_cnt (latency 1 cycle).
REQ-019 SHALL keep out_valid and out_data stable while out_valid && !out_ready; a transfer completes when out_valid && out_ready, and out_valid then clears unless a new beat is accepted in the same cycle.
REQ-020 SHALL in mode 1 advance ks after each accepted beat as a Galois right-shift LFSR: ks' = (ks>>1) XOR (ks[0] ? TAPS : 0); in mode 0 ks SHALL remain constant.
REQ-021 SHALL use TAPS = 8'hB8 for 8-bit, 16'hB400 for 16-bit and 32'h80200003 for 32-bit widths.
REQ-022 SHALL on key_load load ks with key, except that key==0 with mode=1 loads 1 to avoid LFSR lock-up; beat_cnt SHALL clear to 0.
REQ-023 SHALL complete the pending output beat (if any) across key_load; that beat keeps the old-key result and is not dropped.
REQ-024 SHALL let beat_cnt wrap from 16'hFFFF to 0 without any other effect.
REQ-025 SHALL give key_load priority when key_load and in_valid occur together: the key loads and no beat is accepted.

Reset
REQ-026 SHALL on rst=1 immediately set state=NOKEY, ks=0, out_valid=0, out_data=0, beat_cnt=0, keyed=0, mode register=0, irrespective of clk.
REQ-027 SHALL discard any held output beat on reset mid-stream; after reset deasserts, in_ready SHALL stay 0 until a key_load.

Structure
REQ-028 SHALL take the FSM state enum, the TAPS constants per width and the lfsr_next function from shared package cipher_pkg.
REQ-029 SHALL keep the keystream register and its advance/load logic in sub-module keystream_gen; the handshake, counter and FSM stay in the top level.

Verification
REQ-030 SHALL pass this check: DATA_W=8, mode=0, key=8'hA5, in_data 8'h3C then 8'h3C with out_ready=1 -> out_data 8'h99 twice, beat_cnt=2.
REQ-031 SHALL pass this check: mode=1, key=8'h01, in_data 8'h00, 8'h00, 8'h00 -> out_data 8'h01, 8'hB8, 8'h5C.
REQ-032 SHALL pass this check: mode=1, key=0 -> first output for in_data 8'h00 is 8'h01 (lock-up guard).
REQ-033 SHALL pass this check: out_ready=0 for 3 cycles with out_valid=1 -> out_data held, in_ready=0, no ks advance; with out_ready=1 and in_valid=1 held, one beat per cycle is accepted.
REQ-034 SHALL pass this check: in_valid=1 before any key_load -> in_ready=0, out_valid stays 0; key_load together with in_valid -> no beat accepted that cycle and beat_cnt=0.
REQ-035 SHALL pass this check: rst pulsed mid-stream between clock edges -> out_valid=0, keyed=0 and beat_cnt=0 immediately, and in_ready=0 afterwards.
